// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and BCD constants for the stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade that counts 0..9 and emits a carry on the 9->0 wrap
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic             clkIn,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    assign carry = inc & (q == BCD_MAX);

    // advance the decade on inc, wrapping 9 back to 0; clear has priority
    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc)
            q <= carry ? '0 : q + 1'b1;
    end

endmodule

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: counts tickIn rising edges in BCD under start/stop and clear control
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                        clkIn,
    input  logic                        rst,
    input  logic                        tickIn,
    input  logic                        startStop,
    input  logic                        clear,
    output logic [BCD_W*NUM_DIGITS-1:0] digits,
    output logic                        running,
    output logic                        overflow
);

    state_t                state;
    logic                  tick_d;
    logic                  ss_d;
    logic                  tick_rise;
    logic                  ss_rise;
    logic [NUM_DIGITS:0]   inc_chain;

    assign tick_rise    = tickIn & ~tick_d;
    assign ss_rise      = startStop & ~ss_d;
    assign inc_chain[0] = (state == RUN) & tick_rise & ~clear;

    // one-cycle history for rising-edge detection of both level inputs
    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            tick_d <= 1'b0;
            ss_d   <= 1'b0;
        end else begin
            tick_d <= tickIn;
            ss_d   <= startStop;
        end
    end

    // run/pause FSM with registered running flag and sticky overflow
    always_ff @(posedge clkIn or negedge rst) begin
        if (!rst) begin
            state    <= STOPPED;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= STOPPED;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ss_rise) begin
                state   <= (state == RUN) ? PAUSED : RUN;
                running <= (state != RUN);
            end
            if (inc_chain[NUM_DIGITS])
                overflow <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clkIn (clkIn),
            .rst   (rst),
            .clr   (clear),
            .inc   (inc_chain[k]),
            .q     (digits[BCD_W*k +: BCD_W]),
            .carry (inc_chain[k+1])
        );
    end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: directed self-checking bench for bcd_stopwatch
module tb_bcd_stopwatch;

    logic        clkIn = 1'b0;
    logic        rst = 1'b0;
    logic        tickIn = 1'b0;
    logic        startStop = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] digits;
    logic        running;
    logic        overflow;
    int          n_pass = 0;
    int          n_total = 0;

    bcd_stopwatch #(.NUM_DIGITS(4)) dut (
        .clkIn     (clkIn),
        .rst       (rst),
        .tickIn    (tickIn),
        .startStop (startStop),
        .clear     (clear),
        .digits    (digits),
        .running   (running),
        .overflow  (overflow)
    );

    always #5 clkIn = ~clkIn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic ticks(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            tickIn = 1'b1;
            repeat (hi) @(negedge clkIn);
            tickIn = 1'b0;
            repeat (lo) @(negedge clkIn);
        end
    endtask

    task automatic pulse_ss();
        startStop = 1'b1;
        @(negedge clkIn);
        startStop = 1'b0;
        @(negedge clkIn);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clkIn);
        clear = 1'b0;
        @(negedge clkIn);
    endtask

    initial begin
        @(negedge clkIn);
        ticks(3, 1, 1);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        rst = 1'b1;
        @(negedge clkIn);
        ticks(20, 1, 1);
        check("stopped_no_count", 32'(digits), 32'h0);
        check("stopped_running", 32'(running), 32'h0);

        pulse_ss();
        check("start_running", 32'(running), 32'h1);
        tickIn = 1'b1;
        @(negedge clkIn);
        check("first_inc_latency", 32'(digits), 32'h0001);
        repeat (2) @(negedge clkIn);
        tickIn = 1'b0;
        repeat (2) @(negedge clkIn);
        ticks(11, 3, 2);
        check("count_12", 32'(digits), 32'h0012);
        check("count_12_running", 32'(running), 32'h1);

        do_clear();
        check("clear_digits", 32'(digits), 32'h0);
        check("clear_running", 32'(running), 32'h0);
        pulse_ss();
        ticks(5, 1, 1);
        check("pre_pause_5", 32'(digits), 32'h0005);
        pulse_ss();
        check("paused_running", 32'(running), 32'h0);
        ticks(4, 1, 1);
        check("paused_hold", 32'(digits), 32'h0005);
        pulse_ss();
        ticks(3, 1, 1);
        check("resume_8", 32'(digits), 32'h0008);
        check("resume_running", 32'(running), 32'h1);

        tickIn = 1'b1;
        repeat (10) @(negedge clkIn);
        tickIn = 1'b0;
        @(negedge clkIn);
        check("held_high_one_count", 32'(digits), 32'h0009);

        do_clear();
        pulse_ss();
        ticks(9999, 1, 1);
        check("at_9999", 32'(digits), 32'h9999);
        check("at_9999_ovf", 32'(overflow), 32'h0);
        ticks(1, 1, 1);
        check("wrap_0000", 32'(digits), 32'h0000);
        check("wrap_ovf", 32'(overflow), 32'h1);
        ticks(1, 1, 1);
        check("after_wrap_0001", 32'(digits), 32'h0001);
        check("ovf_sticky", 32'(overflow), 32'h1);

        do_clear();
        check("clear_ovf", 32'(overflow), 32'h0);
        startStop = 1'b1;
        tickIn = 1'b1;
        @(negedge clkIn);
        startStop = 1'b0;
        tickIn = 1'b0;
        @(negedge clkIn);
        check("sim_stopped_running", 32'(running), 32'h1);
        check("sim_stopped_digits", 32'(digits), 32'h0000);
        ticks(7, 1, 1);
        startStop = 1'b1;
        tickIn = 1'b1;
        @(negedge clkIn);
        startStop = 1'b0;
        tickIn = 1'b0;
        @(negedge clkIn);
        check("sim_run_digits", 32'(digits), 32'h0008);
        check("sim_run_running", 32'(running), 32'h0);
        pulse_ss();
        clear = 1'b1;
        tickIn = 1'b1;
        @(negedge clkIn);
        clear = 1'b0;
        tickIn = 1'b0;
        @(negedge clkIn);
        check("clr_tick_digits", 32'(digits), 32'h0);
        check("clr_tick_running", 32'(running), 32'h0);

        pulse_ss();
        ticks(347, 1, 1);
        check("at_0347", 32'(digits), 32'h0347);
        #2 rst = 1'b0;
        #1;
        check("async_rst_digits", 32'(digits), 32'h0);
        check("async_rst_running", 32'(running), 32'h0);
        @(negedge clkIn);
        rst = 1'b1;
        @(negedge clkIn);
        ticks(3, 1, 1);
        check("post_rst_no_count", 32'(digits), 32'h0);
        pulse_ss();
        ticks(2, 1, 1);
        check("post_rst_resume", 32'(digits), 32'h0002);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
- Consumer stage directly downstream of slow_clock.
- Takes slow_clock's divided output as a level input `tickIn` in the `clkIn` domain and detects its rising edges.
- Counts those edges in a multi-digit BCD stopwatch with start/stop and clear controls.
- Drives the display/scan logic with packed BCD digits, a running flag and a sticky overflow flag.

Parameters:
- NUM_DIGITS, 4, number of BCD decades in the count (1..8).

Ports:
- clkIn  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- tickIn  input  1  slow_clock output; a rising edge is one count event.
- startStop  input  1  level control; each rising edge toggles run/pause.
- clear  input  1  synchronous clear, level sensitive, highest priority.
- digits  output  4*NUM_DIGITS  packed BCD count; digit 0 (least significant) in bits [3:0].
- running  output  1  1 while the FSM is in RUN.
- overflow  output  1  sticky; set when the count wraps from all-9s to all-0s.

Behaviour:
- Reset (rst=0, asynchronous):
  - digits=0, running=0, overflow=0.
  - FSM to STOPPED.
  - Edge-detect history registers tick_d=0, ss_d=0.
- Edge detection, registered every cycle:
  - tick_d <= tickIn; ss_d <= startStop.
  - tick_rise = tickIn & ~tick_d; ss_rise = startStop & ~ss_d.
  - A tickIn already high when rst releases counts as a rise on the first active edge.
- FSM states: STOPPED (count zero, idle), RUN, PAUSED (count held, nonzero allowed).
  - STOPPED + ss_rise -> RUN.
  - RUN + ss_rise -> PAUSED.
  - PAUSED + ss_rise -> RUN.
  - Any state + clear=1 -> STOPPED, digits=0, overflow=0. Clear overrides ss_rise and tick_rise in the same cycle.
- running = registered (state==RUN). It goes high on the clock edge that samples the ss_rise.
- Counting:
  - On an edge where state (current, pre-edge) == RUN, tick_rise=1 and clear=0, the count increments by 1 in BCD.
  - digits updates at that same edge, so the count is visible one cycle after tickIn is first sampled high.
  - ss_rise and tick_rise in the same cycle from STOPPED/PAUSED: the state goes to RUN and the tick is NOT counted.
  - ss_rise and tick_rise in the same cycle from RUN: the tick IS counted and the state goes to PAUSED.
- BCD arithmetic:
  - Each decade counts 0..9.
  - Carry into decade k+1 only when decades 0..k are all 9 and an increment occurs.
  - Values 10..15 never appear on any decade.
- Wrap: an increment from all-9s (9999 for NUM_DIGITS=4) gives all-0s and sets overflow=1 at the same edge.
  - overflow stays set until clear or reset.
  - Counting continues after the wrap.
- tickIn held high for many cycles produces exactly one count. The next count needs tickIn low for at least one sampled cycle.
- rst asserted mid-count: immediate asynchronous return to the reset values above; no partial update.

Decomposition:
- Shared package (stopwatch_pkg):
  - state encoding constants STOPPED=2'd0, RUN=2'd1, PAUSED=2'd2.
  - BCD_W=4 and BCD_MAX=4'd9.
- Sub-module bcd_digit, one decade:
  - Ports: clkIn, rst, clr, inc, q[3:0], carry.
  - carry = inc & (q==9); q wraps 9->0.
- Top instantiates NUM_DIGITS bcd_digit instances in a generate loop, chaining inc(k+1)=carry(k).
- Top also contains the FSM, both edge detectors and the overflow register.

Test Plan:
- Reset: hold rst=0 with tickIn toggling -> digits=0000, running=0, overflow=0. Release rst with no startStop -> 20 tick rises leave digits=0000.
- Basic count: one startStop pulse, then 12 tickIn rises (tickIn high 3 clkIn cycles, low 2) -> running=1, digits=0x0012. Each increment lands 1 cycle after tickIn goes high.
- Pause/resume: at count 0005, pulse startStop -> running=0; 4 rises -> digits=0005. Pulse again and apply 3 rises -> digits=0008.
- Carry/wrap: run 9999 rises -> digits=0x9999, overflow=0. One more rise -> digits=0x0000, overflow=1. One more -> 0x0001 with overflow still 1.
- Simultaneous events:
  - startStop and tickIn rise in the same cycle from STOPPED -> running=1, digits=0000.
  - From RUN at 0007 -> digits=0008, running=0.
  - clear with tickIn rise while RUN -> digits=0000, STOPPED, overflow=0.
- Async reset mid-run: at digits=0x0347 assert rst between clkIn edges -> outputs zero before the next clkIn edge. After release, a startStop pulse is required before counting resumes.
